mua_reorder_nch: RTL and testbench

MUA_REORDER_NCH -- requirements
Module: mua_reorder_nch

---
 rtl/mua_reorder_pkg.sv | 17 +
 rtl/mua_frame_bank.sv | 43 ++++
 rtl/mua_reorder_nch.sv | 134 +++++++++++++
 tb/tb_mua_reorder_nch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mua_reorder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mua_reorder_pkg
// Purpose  : Shared constants and helpers for the N-channel frame reorderer.
// Revision : 1.0  initial release
// ============================================================================
package mua_reorder_pkg;

  localparam int c_data_w = 32;
  localparam int c_cnt_w  = 16;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mua_frame_bank.sv
`default_nettype none
// ============================================================================
// Module   : mua_frame_bank
// Purpose  : One frame buffer: register array, sync write, async read, full flag.
// Revision : 1.0  initial release
// ============================================================================
module mua_frame_bank
  import mua_reorder_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int N_CH   = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_set_full,
  input  logic              i_clr_full,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full
);

  logic [DATA_W-1:0] r_mem [N_CH];
  logic              r_full;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          r_full <= 1'b0;
    else if (i_set_full) r_full <= 1'b1;
    else if (i_clr_full) r_full <= 1'b0;
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_full  = r_full;

endmodule
`default_nettype wire

// File: rtl/mua_reorder_nch.sv
`default_nettype none
// ============================================================================
// Module   : mua_reorder_nch
// Purpose  : Ping-pong frame reorderer, physical -> logical channel order via map.
//            Optional statistics counters enabled by MUA_REORDER_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module mua_reorder_nch
  import mua_reorder_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int N_CH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   cfg_we,
  input  logic [idx_w(N_CH)-1:0] cfg_addr,
  input  logic [idx_w(N_CH)-1:0] cfg_data,
  output logic                   err_frame,
  output logic [c_cnt_w-1:0]     frame_cnt,
  output logic [c_cnt_w-1:0]     err_cnt
);

  localparam int               IDX_W      = idx_w(N_CH);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_CH - 1);

  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic [IDX_W-1:0] r_map [N_CH];
  logic             r_err;

  logic [1:0]        w_full;
  logic [DATA_W-1:0] w_rdata [2];
  logic              w_acc;
  logic              w_at_end;
  logic              w_done;
  logic              w_bad;
  logic              w_pop;
  logic              w_free;

  // Gating with rst_n keeps in_ready low throughout reset and high on release.
  assign in_ready  = rst_n & ~w_full[r_wr_bank];
  assign w_acc     = in_valid & in_ready;
  assign w_at_end  = (r_wr_idx == c_last_idx);
  assign w_done    = w_acc & w_at_end & in_last;
  assign w_bad     = w_acc & (w_at_end ^ in_last);

  assign out_valid = w_full[r_rd_bank];
  assign out_last  = out_valid & (r_rd_idx == c_last_idx);
  assign out_data  = w_rdata[r_rd_bank];
  assign w_pop     = out_valid & out_ready;
  assign w_free    = w_pop & out_last;
  assign err_frame = r_err;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mua_frame_bank #(
      .DATA_W (DATA_W),
      .N_CH   (N_CH),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_we       (w_acc & ~w_bad & (r_wr_bank == 1'(b))),
      .i_waddr    (r_map[r_wr_idx]),
      .i_wdata    (in_data),
      .i_set_full (w_done & (r_wr_bank == 1'(b))),
      .i_clr_full (w_free & (r_rd_bank == 1'(b))),
      .i_raddr    (r_rd_idx),
      .o_rdata    (w_rdata[b]),
      .o_full     (w_full[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_bad;
      // A malformed frame is dropped in place: same bank, index back to zero.
      if (w_done || w_bad) r_wr_idx <= '0;
      else if (w_acc)      r_wr_idx <= r_wr_idx + 1'b1;
      if (w_done) r_wr_bank <= ~r_wr_bank;
      if (w_pop) begin
        r_rd_idx <= out_last ? '0 : r_rd_idx + 1'b1;
        if (out_last) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) r_map[i] <= IDX_W'(i);
    end else if (cfg_we) begin
      r_map[cfg_addr] <= cfg_data;
    end
  end

`ifdef MUA_REORDER_STATS_EN
  logic [c_cnt_w-1:0] r_frame_cnt;
  logic [c_cnt_w-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_free && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (r_err  && (r_err_cnt   != '1)) r_err_cnt   <= r_err_cnt + 1'b1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mua_reorder_nch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mua_reorder_nch
// Purpose  : Directed self-checking bench for mua_reorder_nch (N_CH = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_mua_reorder_nch;

`ifdef MUA_REORDER_STATS_EN
  localparam int c_stats = 1;
`else
  localparam int c_stats = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] out_data;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        err_frame;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  mua_reorder_nch #(.DATA_W(16), .N_CH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .err_frame (err_frame),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic        exp_last_q[$];
  logic [15:0] fbuf [4];
  logic [1:0]  mmap [4];
  int          widx;
  int          err_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, score any output pop, model any input accept.
  task automatic cycle(input bit v, input logic [15:0] d, input bit l, input bit r);
    bit err_now;
    err_now   = 1'b0;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        chk("out_data", out_data, exp_q.pop_front());
        chk("out_last", out_last, exp_last_q.pop_front());
      end
    end
    if (v && in_ready) begin
      fbuf[mmap[widx]] = d;
      if (widx == 3 && l) begin
        for (int k = 0; k < 4; k++) begin
          exp_q.push_back(fbuf[k]);
          exp_last_q.push_back(k == 3);
        end
        widx = 0;
      end else if (widx == 3 || l) begin
        widx = 0;
        err_now = 1'b1;
        err_total++;
      end else begin
        widx++;
      end
    end
    @(posedge clk);
    #1;
    chk("err_frame", err_frame, err_now);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    cfg_we   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err_frame", err_frame, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    exp_q.delete();
    exp_last_q.delete();
    widx = 0;
    err_total = 0;
    for (int k = 0; k < 4; k++) mmap[k] = 2'(k);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
  endtask

  task automatic cfg(input logic [1:0] a, input logic [1:0] dv);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = dv;
    mmap[a]  = dv;
    cycle(0, 16'h0, 0, 1);
    cfg_we   = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) cycle(0, 16'h0, 0, 1);
    chk(tag, exp_q.size(), 0);
    cycle(0, 16'h0, 0, 1);
    chk({tag, "_idle"}, out_valid, 0);
  endtask

  initial begin
    int w;
    int idle;
    int stall;
    bit a;
    bit started;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0; rst_n = 0;

    do_reset();

    // Identity map: first word visible the cycle after the last word is taken.
    cycle(1, 16'hAAAA, 0, 1);
    cycle(1, 16'hBBBB, 0, 1);
    cycle(1, 16'hCCCC, 0, 1);
    cycle(1, 16'hDDDD, 1, 1);
    chk("id_lat_valid", out_valid, 1);
    chk("id_lat_data", out_data, 16'hAAAA);
    drain("id_drain");

    // Reversed map, output held under backpressure.
    cfg(2'd0, 2'd3); cfg(2'd1, 2'd2); cfg(2'd2, 2'd1); cfg(2'd3, 2'd0);
    cycle(1, 16'hAAAA, 0, 0);
    cycle(1, 16'hBBBB, 0, 0);
    cycle(1, 16'hCCCC, 0, 0);
    cycle(1, 16'hDDDD, 1, 0);
    cycle(0, 16'h0, 0, 0);
    chk("rev_hold_data", out_data, 16'hDDDD);
    chk("rev_hold_last", out_last, 0);
    drain("rev_drain");

    // Three frames offered while out_ready is low for 10 cycles.
    w = 0;
    for (int c = 0; c < 80 && (w < 12 || exp_q.size() > 0); c++) begin
      if (c == 8 || c == 9) chk("bp_in_ready_low", in_ready, 0);
      a = in_ready && (w < 12);
      cycle(w < 12, 16'(16'h1000 + w), (w % 4) == 3, c >= 10);
      if (a) w++;
    end
    chk("bp_words", w, 12);
    chk("bp_drained", exp_q.size(), 0);

    // Short frame, then a frame missing in_last, then a good frame.
    cycle(1, 16'h2001, 0, 1);
    cycle(1, 16'h2002, 0, 1);
    cycle(1, 16'h2003, 1, 1);
    chk("short_no_out", out_valid, 0);
    for (int k = 0; k < 4; k++) cycle(1, 16'(16'h3000 + k), 0, 1);
    cycle(0, 16'h0, 0, 1);
    chk("err_no_out", out_valid, 0);
    chk("err_cnt", err_cnt, 32'(c_stats * 2));
    for (int k = 0; k < 4; k++) cycle(1, 16'(16'h4000 + k), k == 3, 1);
    drain("good_after_err");

    // Reset mid-frame drops data and restores the identity map.
    cycle(1, 16'h5000, 0, 1);
    cycle(1, 16'h5001, 0, 1);
    do_reset();
    cycle(1, 16'h6000, 0, 0);
    cycle(1, 16'h6001, 0, 0);
    cycle(1, 16'h6002, 0, 0);
    cycle(1, 16'h6003, 1, 0);
    chk("mid_rst_data", out_data, 16'h6000);
    drain("mid_rst_drain");
    chk("mid_rst_frames", frame_cnt, 32'(c_stats));

    // 100 back-to-back frames at full rate.
    do_reset();
    w = 0; idle = 0; stall = 0; started = 0;
    for (int c = 0; c < 1000 && (w < 400 || exp_q.size() > 0); c++) begin
      if (out_valid) started = 1;
      else if (started && exp_q.size() > 0) idle++;
      if (w < 400 && !in_ready) stall++;
      a = in_ready && (w < 400);
      cycle(w < 400, 16'(w * 7 + 3), (w % 4) == 3, 1);
      if (a) w++;
    end
    chk("stream_words", w, 400);
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_idle", idle, 0);
    chk("stream_stall", stall, 0);
    chk("stream_frame_cnt", frame_cnt, 32'(c_stats * 100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
